fbosc_monitor: RTL and testbench

Phase-lock monitor that sits directly downstream of the two-flop feedback oscillator (`y1`/`y2` pair toggling at clk/2). It samples both phases each cycle and checks that they are complementary and toggling. After enough consecutive good cycles it declares lock, then emits a divided tick. Any violation after lock latches a fault until software clears it.

---
 rtl/fbosc_monitor.sv | 127 ++++++++++++
 tb/tb_fbosc_monitor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fbosc_monitor.sv
// Phase-lock monitor for the two-flop clk/2 feedback oscillator: qualifies y1/y2, locks, divides, latches faults.
// Optional macro FBOSC_MON_ERRCNT_EN adds the 8-bit saturating violation counter; otherwise err_cnt reads 0.
module fbosc_monitor #(
    parameter int LOCK_CNT = 4,
    parameter int DIV_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             y1,
    input  logic             y2,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             clr_fault,
    output logic             locked,
    output logic             fault,
    output logic             tick,
    output logic [7:0]       err_cnt
);

    localparam int LKW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam logic [LKW-1:0] LK_LAST = LKW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {ACQ, LOCKED, FAULT} state_t;

    state_t           state_reg, state_next;
    logic             s1_reg, s2_reg, p1_reg;
    logic [2:0]       warm_reg;
    logic [LKW-1:0]   lk_cnt_reg, lk_cnt_next;
    logic [DIV_W-1:0] dcnt_reg, dcnt_next;
    logic [DIV_W-1:0] div_lim;
    logic             tick_reg, tick_next;
    logic             hist_v, good, bad;

    // History is trusted only once both sample and history flops hold post-reset data.
    assign hist_v  = warm_reg[2];
    assign good    = hist_v & (s1_reg ^ s2_reg) & (s1_reg ^ p1_reg);
    assign bad     = hist_v & ~good;
    assign div_lim = (div_ratio == '0) ? DIV_W'(1) : div_ratio;

    always_comb begin
        state_next  = state_reg;
        lk_cnt_next = lk_cnt_reg;
        dcnt_next   = '0;
        tick_next   = 1'b0;
        case (state_reg)
            ACQ: begin
                if (good) begin
                    if (lk_cnt_reg == LK_LAST) begin
                        state_next  = LOCKED;
                        lk_cnt_next = '0;
                    end else begin
                        lk_cnt_next = lk_cnt_reg + 1'b1;
                    end
                end else if (bad) begin
                    lk_cnt_next = '0;
                end
            end
            LOCKED: begin
                lk_cnt_next = '0;
                if (bad) begin
                    state_next = FAULT;
                end else if (good) begin
                    // A shrunken ratio below dcnt lets the counter run to all-ones and wrap silently.
                    if (dcnt_reg == div_lim - 1'b1) begin
                        tick_next = 1'b1;
                    end else begin
                        dcnt_next = dcnt_reg + 1'b1;
                    end
                end else begin
                    dcnt_next = dcnt_reg;
                end
            end
            FAULT: begin
                lk_cnt_next = '0;
                if (clr_fault) begin
                    state_next = ACQ;
                end
            end
            default: begin
                state_next  = ACQ;
                lk_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ACQ;
            s1_reg     <= 1'b0;
            s2_reg     <= 1'b1;
            p1_reg     <= 1'b0;
            warm_reg   <= '0;
            lk_cnt_reg <= '0;
            dcnt_reg   <= '0;
            tick_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            s1_reg     <= y1;
            s2_reg     <= y2;
            p1_reg     <= s1_reg;
            warm_reg   <= {warm_reg[1:0], 1'b1};
            lk_cnt_reg <= lk_cnt_next;
            dcnt_reg   <= dcnt_next;
            tick_reg   <= tick_next;
        end
    end

    assign locked = (state_reg == LOCKED);
    assign fault  = (state_reg == FAULT);
    assign tick   = tick_reg;

`ifdef FBOSC_MON_ERRCNT_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_reg <= 8'd0;
        end else if ((state_reg == LOCKED) && bad && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fbosc_monitor.sv
// Directed bench for fbosc_monitor: vector table for lock/tick/fault/clear, plus reset, glitch and saturation runs.
module tb_fbosc_monitor;

`ifdef FBOSC_MON_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       y1 = 1'b0;
    logic       y2 = 1'b1;
    logic [7:0] div_ratio = 8'd3;
    logic       clr_fault = 1'b0;
    logic       locked, fault, tick;
    logic [7:0] err_cnt;

    int n_pass = 0;
    int n_total = 0;
    logic ph = 1'b1;

    fbosc_monitor #(.LOCK_CNT(4), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .y1(y1), .y2(y2), .div_ratio(div_ratio),
        .clr_fault(clr_fault), .locked(locked), .fault(fault), .tick(tick), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, y1, y2, clr;
        logic [7:0] div;
        logic       locked, fault, tick;
        logic [7:0] err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic a, input logic b, input logic c, input logic [7:0] d,
                       input logic lk, input logic ft, input logic tk, input logic [7:0] e);
        vec_t v;
        v.rst_n = r; v.y1 = a; v.y2 = b; v.clr = c; v.div = d;
        v.locked = lk; v.fault = ft; v.tick = tk; v.err = ERR_EN ? e : 8'd0;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0d: got %0d, expected %0d", name, idx, act, exp);
    endtask

    task automatic step(input logic r, input logic a, input logic b, input logic c);
        rst_n = r; y1 = a; y2 = b; clr_fault = c;
        @(posedge clk);
        #1;
    endtask

    task automatic hstep(input logic c);
        ph = ~ph;
        step(1'b1, ph, ~ph, c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] gl;
        int k;
        // rst, y1, y2, clr, div, locked, fault, tick, err
        add(0, 0, 1, 0, 3, 0, 0, 0, 0);
        add(0, 1, 0, 0, 3, 0, 0, 0, 0);
        add(1, 0, 1, 0, 3, 0, 0, 0, 0);  // E1
        add(1, 1, 0, 0, 3, 0, 0, 0, 0);
        add(1, 0, 1, 0, 3, 0, 0, 0, 0);
        add(1, 1, 0, 0, 3, 0, 0, 0, 0);  // E4 first good
        add(1, 0, 1, 0, 3, 0, 0, 0, 0);
        add(1, 1, 0, 0, 3, 0, 0, 0, 0);
        add(1, 0, 1, 0, 3, 1, 0, 0, 0);  // E7 lock
        add(1, 1, 0, 0, 3, 1, 0, 0, 0);
        add(1, 0, 1, 0, 3, 1, 0, 0, 0);
        add(1, 1, 0, 0, 3, 1, 0, 1, 0);  // E10 tick
        add(1, 0, 1, 0, 3, 1, 0, 0, 0);
        add(1, 1, 0, 0, 3, 1, 0, 0, 0);
        add(1, 0, 1, 0, 3, 1, 0, 1, 0);  // E13 tick
        add(1, 1, 1, 0, 3, 1, 0, 0, 0);  // stuck sample
        add(1, 0, 1, 0, 3, 0, 1, 0, 1);  // fault one edge later
        add(1, 1, 1, 0, 3, 0, 1, 0, 1);
        add(1, 0, 1, 0, 3, 0, 1, 0, 1);  // bad in FAULT: err holds
        add(1, 1, 0, 1, 3, 0, 0, 0, 1);  // clear
        add(1, 0, 1, 0, 3, 0, 0, 0, 1);
        add(1, 1, 0, 0, 3, 0, 0, 0, 1);
        add(1, 0, 1, 0, 3, 0, 0, 0, 1);
        add(1, 1, 0, 0, 3, 1, 0, 0, 1);  // relock after 4 good
        add(1, 0, 1, 0, 3, 1, 0, 0, 1);
        add(1, 1, 0, 0, 3, 1, 0, 0, 1);
        add(1, 0, 1, 0, 3, 1, 0, 1, 1);  // dcnt restarted at 0
        add(1, 1, 0, 1, 3, 1, 0, 0, 1);  // clr ignored when locked
        add(1, 0, 1, 0, 2, 1, 0, 1, 1);  // new ratio used at next compare
        add(1, 1, 0, 0, 2, 1, 0, 0, 1);
        add(1, 0, 1, 0, 2, 1, 0, 1, 1);
        add(1, 1, 0, 0, 0, 1, 0, 1, 1);  // ratio 0 = every good cycle
        add(1, 0, 1, 0, 0, 1, 0, 1, 1);
        add(1, 1, 0, 0, 3, 1, 0, 0, 1);
        add(1, 0, 1, 0, 3, 1, 0, 0, 1);  // dcnt now 2

        foreach (tbl[i]) begin
            div_ratio = tbl[i].div;
            step(tbl[i].rst_n, tbl[i].y1, tbl[i].y2, tbl[i].clr);
            chk("tbl_locked", i, {7'd0, locked}, {7'd0, tbl[i].locked});
            chk("tbl_fault",  i, {7'd0, fault},  {7'd0, tbl[i].fault});
            chk("tbl_tick",   i, {7'd0, tick},   {7'd0, tbl[i].tick});
            chk("tbl_err",    i, err_cnt, tbl[i].err);
            $display("vec %0d: rst_n=%b y=%b%b clr=%b div=%0d -> locked=%b fault=%b tick=%b err=%0d",
                     i, tbl[i].rst_n, tbl[i].y1, tbl[i].y2, tbl[i].clr, tbl[i].div, locked, fault, tick, err_cnt);
        end

        // Reset mid-run while locked with dcnt=2.
        div_ratio = 8'd3;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_locked", 0, {7'd0, locked}, 8'd0);
        chk("rst_fault",  0, {7'd0, fault},  8'd0);
        chk("rst_tick",   0, {7'd0, tick},   8'd0);
        chk("rst_err",    0, err_cnt, 8'd0);
        $display("reset mid-run: locked=%b fault=%b tick=%b err=%0d", locked, fault, tick, err_cnt);
        ph = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            hstep(1'b0);
            chk("relock_locked", e, {7'd0, locked}, {7'd0, (e >= 7)});
            chk("relock_tick",   e, {7'd0, tick},   {7'd0, (e == 10)});
            $display("post-reset edge %0d: locked=%b tick=%b", e, locked, tick);
        end

        // Acquisition glitch: repeated sample after three good cycles.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        gl = 11'b10101001010;  // y1 for E1..E11, read from bit 0
        for (int e = 1; e <= 11; e++) begin
            step(1'b1, gl[e-1], ~gl[e-1], 1'b0);
            chk("glitch_locked", e, {7'd0, locked}, {7'd0, (e == 11)});
            $display("glitch edge %0d: y1=%b locked=%b", e, gl[e-1], locked);
        end
        ph = gl[10];

        // Saturation: repeated fault/clear/relock.
        for (int it = 0; it < 260; it++) begin
            ph = ~ph;
            step(1'b1, ph, ph, 1'b0);
            hstep(1'b0);
            hstep(1'b1);
            k = 0;
            while (!locked && k < 10) begin
                hstep(1'b0);
                k++;
            end
            chk("sat_relock", it, {7'd0, locked}, 8'd1);
            if (it == 0 || it == 254 || it == 255 || it == 259) begin
                chk("sat_err", it, err_cnt, ERR_EN ? ((it + 1 > 255) ? 8'd255 : 8'(it + 1)) : 8'd0);
                $display("saturation iter %0d: err=%0d", it, err_cnt);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
